// File: rtl/usbdev_pkg.sv
// Shared types for the USB device always-on wake sequencer.
package usbdev_pkg;

    typedef enum logic [2:0] {
        AON_IDLE    = 3'd0,
        AON_REQ     = 3'd1,
        AON_MONITOR = 3'd2,
        AON_WAKE    = 3'd3,
        AON_ACK     = 3'd4
    } aon_wake_seq_state_e;

    typedef enum logic [1:0] {
        REASON_NONE       = 2'd0,
        REASON_NOT_IDLE   = 2'd1,
        REASON_BUS_RESET  = 2'd2,
        REASON_SENSE_LOST = 2'd3
    } aon_wake_reason_e;

    localparam int unsigned AonHandoffTimeoutDefault = 16;

    // Loss of VBUS sense outranks a bus reset, which outranks plain bus activity.
    function automatic aon_wake_reason_e aon_wake_reason(input logic not_idle,
                                                         input logic bus_reset,
                                                         input logic sense_lost);
        if (sense_lost)     return REASON_SENSE_LOST;
        else if (bus_reset) return REASON_BUS_RESET;
        else if (not_idle)  return REASON_NOT_IDLE;
        else                return REASON_NONE;
    endfunction

endpackage

// File: rtl/usbdev_aon_wake_seq.sv
// AON wake sequencer: hand-off to the wake detector, wake capture, ack and return of control.
// Optional self-ack out of WAKE is enabled by defining USBDEV_AON_WAKE_SEQ_AUTOACK_EN.
module usbdev_aon_wake_seq
    import usbdev_pkg::*;
#(
    parameter int unsigned HandoffTimeout = AonHandoffTimeoutDefault,
    parameter int unsigned CntW           = 8,
    parameter int unsigned AutoAckDelay   = 32
) (
    input  logic            clk_aon_i,
    input  logic            rst_aon_i,
    input  logic            suspend_req_i,
    input  logic            wake_ack_i,
    input  logic            wake_req_aon_i,
    input  logic            bus_not_idle_aon_i,
    input  logic            bus_reset_aon_i,
    input  logic            sense_lost_aon_i,
    input  logic            wake_detect_active_aon_i,
    output logic            suspend_req_aon_o,
    output logic            wake_ack_aon_o,
    output logic            wake_event_o,
    output logic [1:0]      wake_reason_o,
    output logic [CntW-1:0] wake_cnt_o,
    output logic            handoff_err_o,
    output logic [2:0]      state_o
);

    // One down-counter serves both the REQ timeout and the WAKE self-ack delay.
    localparam int unsigned TmrMax = (HandoffTimeout > AutoAckDelay) ? HandoffTimeout : AutoAckDelay;
    localparam int unsigned TmrW   = $clog2(TmrMax);

    aon_wake_seq_state_e state_q, state_d;
    aon_wake_reason_e    reason_q, reason_d;
    logic [TmrW-1:0]     tmr_q, tmr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                sreq_q, ack_q, event_q, err_q;
    logic                event_d, err_d;

    always_comb begin
        state_d  = state_q;
        reason_d = reason_q;
        tmr_d    = tmr_q;
        cnt_d    = cnt_q;
        event_d  = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            AON_IDLE: begin
                // A detector that is already active is a stale hand-off; ignore it.
                if (suspend_req_i && !wake_detect_active_aon_i) begin
                    state_d = AON_REQ;
                    tmr_d   = TmrW'(HandoffTimeout - 1);
                end
            end
            AON_REQ: begin
                if (wake_detect_active_aon_i) begin
                    state_d = AON_MONITOR;
                end else if (!suspend_req_i) begin
                    state_d = AON_IDLE;
                end else if (tmr_q == '0) begin
                    state_d = AON_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            AON_MONITOR: begin
                if (wake_req_aon_i) begin
                    state_d  = AON_WAKE;
                    reason_d = aon_wake_reason(bus_not_idle_aon_i, bus_reset_aon_i,
                                               sense_lost_aon_i);
                    event_d  = 1'b1;
                    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
`ifdef USBDEV_AON_WAKE_SEQ_AUTOACK_EN
                    tmr_d    = TmrW'(AutoAckDelay - 1);
`endif
                end else if (wake_ack_i) begin
                    state_d  = AON_ACK;
                    reason_d = REASON_NONE;
                end else if (!wake_detect_active_aon_i) begin
                    state_d = AON_IDLE;
                end
            end
            AON_WAKE: begin
`ifdef USBDEV_AON_WAKE_SEQ_AUTOACK_EN
                if (wake_ack_i || tmr_q == '0) begin
                    state_d = AON_ACK;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
`else
                if (wake_ack_i) begin
                    state_d = AON_ACK;
                end
`endif
            end
            AON_ACK: begin
                if (!wake_detect_active_aon_i) begin
                    state_d = AON_IDLE;
                end
            end
            default: state_d = AON_IDLE;
        endcase
    end

    // Handshake outputs follow the next state so they change on the same edge as the state.
    always_ff @(posedge clk_aon_i) begin
        if (rst_aon_i) begin
            state_q  <= AON_IDLE;
            reason_q <= REASON_NONE;
            tmr_q    <= '0;
            cnt_q    <= '0;
            sreq_q   <= 1'b0;
            ack_q    <= 1'b0;
            event_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            reason_q <= reason_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            sreq_q   <= (state_d == AON_REQ);
            ack_q    <= (state_d == AON_ACK);
            event_q  <= event_d;
            err_q    <= err_d;
        end
    end

    assign suspend_req_aon_o = sreq_q;
    assign wake_ack_aon_o    = ack_q;
    assign wake_event_o      = event_q;
    assign wake_reason_o     = reason_q;
    assign wake_cnt_o        = cnt_q;
    assign handoff_err_o     = err_q;
    assign state_o           = state_q;

endmodule
